// File: rtl/sid_pkg.sv
// Shared constants and types for the SID host register bank: address map,
// voice count, write-FSM encoding and the latched write request.
package sid_pkg;

    localparam int         NUM_VOICES = 3;
    localparam logic [1:0] VOICE_FILT = 2'd3;

    localparam logic [2:0] REG_FREQ_LO = 3'd0;
    localparam logic [2:0] REG_FREQ_HI = 3'd1;
    localparam logic [2:0] REG_PW_LO   = 3'd2;
    localparam logic [2:0] REG_PW_HI   = 3'd3;
    localparam logic [2:0] REG_AD      = 3'd4;
    localparam logic [2:0] REG_SR      = 3'd5;
    localparam logic [2:0] REG_WAV     = 3'd6;

    localparam logic [2:0] REG_FC_LO    = 3'd0;
    localparam logic [2:0] REG_FC_HI    = 3'd1;
    localparam logic [2:0] REG_RES_FILT = 3'd2;
    localparam logic [2:0] REG_MODE_VOL = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HOLD  = 2'd2
    } wr_state_e;

    // Field order mirrors the pin packing {ui_in[6:0], uio_in}.
    typedef struct packed {
        logic [1:0] rsv;
        logic [1:0] voice;
        logic [2:0] addr;
        logic [7:0] data;
    } wr_req_t;

    // A request targets a voice only when its reserved bits are clear.
    function automatic logic voice_hit(input wr_req_t req, input logic [1:0] voice);
        return (req.rsv == 2'b00) && (req.voice == voice);
    endfunction

endpackage

// File: rtl/sid_sync2.sv
// Two-flop synchroniser for a single asynchronous control input.
module sid_sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/sid_reg_bank.sv
// Host write port and register file: synchronises the write strobe, commits one
// register write per strobe pulse and drives the voice/filter parameter buses.
module sid_reg_bank
    import sid_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  ui_in,
    input  logic [7:0]  uio_in,
    output logic [47:0] voice_freq,
    output logic [35:0] voice_pw,
    output logic [23:0] voice_ad,
    output logic [23:0] voice_sr,
    output logic [23:0] voice_wav,
    output logic [10:0] filt_fc,
    output logic [7:0]  filt_res_filt,
    output logic [7:0]  filt_mode_vol,
    output logic        wr_strobe,
    output logic [1:0]  wr_voice,
    output logic [2:0]  wr_addr
);

    logic      we_s;
    logic      commit_s;

    wr_state_e state_q,     state_d;
    wr_req_t   req_q,       req_d;
    logic      wr_strobe_q, wr_strobe_d;

    logic [47:0] freq_q,     freq_d;
    logic [35:0] pw_q,       pw_d;
    logic [23:0] ad_q,       ad_d;
    logic [23:0] sr_q,       sr_d;
    logic [23:0] wav_q,      wav_d;
    logic [10:0] fc_q,       fc_d;
    logic [7:0]  res_filt_q, res_filt_d;
    logic [7:0]  mode_vol_q, mode_vol_d;

    sid_sync2 u_we_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d_i   (ui_in[7]),
        .q_o   (we_s)
    );

    // Write FSM: accept on synchronised strobe, commit once, wait for release.
    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        wr_strobe_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (we_s) begin
                    req_d       = {ui_in[6:0], uio_in};
                    state_d     = ST_WRITE;
                    wr_strobe_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (we_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HOLD: begin
                if (we_s) begin
                    state_d = ST_HOLD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The register file is written on the edge that leaves WRITE.
    assign commit_s = (state_q == ST_WRITE);

    // Address decode: a non-selected request falls through to the default arm.
    always_comb begin
        freq_d     = freq_q;
        pw_d       = pw_q;
        ad_d       = ad_q;
        sr_d       = sr_q;
        wav_d      = wav_q;
        fc_d       = fc_q;
        res_filt_d = res_filt_q;
        mode_vol_d = mode_vol_q;
        for (int v = 0; v < NUM_VOICES; v++) begin
            case ({commit_s && voice_hit(req_q, 2'(v)), req_q.addr})
                {1'b1, REG_FREQ_LO}: freq_d[16*v +: 8]   = req_q.data;
                {1'b1, REG_FREQ_HI}: freq_d[16*v+8 +: 8] = req_q.data;
                {1'b1, REG_PW_LO}:   pw_d[12*v +: 8]     = req_q.data;
                {1'b1, REG_PW_HI}:   pw_d[12*v+8 +: 4]   = req_q.data[3:0];
                {1'b1, REG_AD}:      ad_d[8*v +: 8]      = req_q.data;
                {1'b1, REG_SR}:      sr_d[8*v +: 8]      = req_q.data;
                {1'b1, REG_WAV}:     wav_d[8*v +: 8]     = req_q.data;
                default: ;
            endcase
        end
        case ({commit_s && voice_hit(req_q, VOICE_FILT), req_q.addr})
            {1'b1, REG_FC_LO}:    fc_d[2:0]  = req_q.data[2:0];
            {1'b1, REG_FC_HI}:    fc_d[10:3] = req_q.data;
            {1'b1, REG_RES_FILT}: res_filt_d = req_q.data;
            {1'b1, REG_MODE_VOL}: mode_vol_d = req_q.data;
            default: ;
        endcase
    end

    // State, latched request and register file flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_q       <= '0;
            wr_strobe_q <= 1'b0;
            freq_q      <= 48'h0;
            pw_q        <= 36'h0;
            ad_q        <= 24'h0;
            sr_q        <= 24'h0;
            wav_q       <= 24'h0;
            fc_q        <= 11'h0;
            res_filt_q  <= 8'h00;
            mode_vol_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            wr_strobe_q <= wr_strobe_d;
            freq_q      <= freq_d;
            pw_q        <= pw_d;
            ad_q        <= ad_d;
            sr_q        <= sr_d;
            wav_q       <= wav_d;
            fc_q        <= fc_d;
            res_filt_q  <= res_filt_d;
            mode_vol_q  <= mode_vol_d;
        end
    end

    assign voice_freq    = freq_q;
    assign voice_pw      = pw_q;
    assign voice_ad      = ad_q;
    assign voice_sr      = sr_q;
    assign voice_wav     = wav_q;
    assign filt_fc       = fc_q;
    assign filt_res_filt = res_filt_q;
    assign filt_mode_vol = mode_vol_q;
    assign wr_strobe     = wr_strobe_q;
    assign wr_voice      = req_q.voice;
    assign wr_addr       = req_q.addr;

endmodule

// File: tb/tb_sid_reg_bank.sv
// Self-checking bench for sid_reg_bank: directed and random host writes checked
// against an array-based register model, including strobe timing and resets.
module tb_sid_reg_bank;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  ui_in = 8'h00;
    logic [7:0]  uio_in = 8'h00;
    logic [47:0] voice_freq;
    logic [35:0] voice_pw;
    logic [23:0] voice_ad;
    logic [23:0] voice_sr;
    logic [23:0] voice_wav;
    logic [10:0] filt_fc;
    logic [7:0]  filt_res_filt;
    logic [7:0]  filt_mode_vol;
    logic        wr_strobe;
    logic [1:0]  wr_voice;
    logic [2:0]  wr_addr;

    sid_reg_bank dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .ui_in         (ui_in),
        .uio_in        (uio_in),
        .voice_freq    (voice_freq),
        .voice_pw      (voice_pw),
        .voice_ad      (voice_ad),
        .voice_sr      (voice_sr),
        .voice_wav     (voice_wav),
        .filt_fc       (filt_fc),
        .filt_res_filt (filt_res_filt),
        .filt_mode_vol (filt_mode_vol),
        .wr_strobe     (wr_strobe),
        .wr_voice      (wr_voice),
        .wr_addr       (wr_addr)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int strobe_cnt = 0;
    int exp_strobes = 0;

    // Count strobe-high cycles; one-cycle pulses make this the pulse count.
    always @(negedge clk) begin
        if (wr_strobe) strobe_cnt++;
    end

    // Reference model: plain per-register arrays.
    logic [15:0] m_freq [3];
    logic [11:0] m_pw   [3];
    logic [7:0]  m_ad   [3];
    logic [7:0]  m_sr   [3];
    logic [7:0]  m_wav  [3];
    logic [10:0] m_fc;
    logic [7:0]  m_res;
    logic [7:0]  m_mv;
    logic [1:0]  m_voice;
    logic [2:0]  m_addr;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_freq[i] = 16'h0; m_pw[i] = 12'h0;
            m_ad[i] = 8'h0; m_sr[i] = 8'h0; m_wav[i] = 8'h0;
        end
        m_fc = 11'h0; m_res = 8'h0; m_mv = 8'h0;
        m_voice = 2'd0; m_addr = 3'd0;
    endtask

    task automatic model_write(input int voice, input int addr, input logic [7:0] data, input int rsv);
        m_voice = 2'(voice);
        m_addr  = 3'(addr);
        if (rsv != 0) return;
        if (voice < 3) begin
            case (addr)
                0: m_freq[voice][7:0]  = data;
                1: m_freq[voice][15:8] = data;
                2: m_pw[voice][7:0]    = data;
                3: m_pw[voice][11:8]   = data[3:0];
                4: m_ad[voice]         = data;
                5: m_sr[voice]         = data;
                6: m_wav[voice]        = data;
                default: ;
            endcase
        end else begin
            case (addr)
                0: m_fc[2:0]  = data[2:0];
                1: m_fc[10:3] = data;
                2: m_res      = data;
                3: m_mv       = data;
                default: ;
            endcase
        end
    endtask

    task automatic check_regs(input string tag);
        check_eq({tag, ".freq"}, 64'(voice_freq), 64'({m_freq[2], m_freq[1], m_freq[0]}));
        check_eq({tag, ".pw"},   64'(voice_pw),   64'({m_pw[2], m_pw[1], m_pw[0]}));
        check_eq({tag, ".ad"},   64'(voice_ad),   64'({m_ad[2], m_ad[1], m_ad[0]}));
        check_eq({tag, ".sr"},   64'(voice_sr),   64'({m_sr[2], m_sr[1], m_sr[0]}));
        check_eq({tag, ".wav"},  64'(voice_wav),  64'({m_wav[2], m_wav[1], m_wav[0]}));
        check_eq({tag, ".fc"},   64'(filt_fc),    64'(m_fc));
        check_eq({tag, ".res"},  64'(filt_res_filt), 64'(m_res));
        check_eq({tag, ".mv"},   64'(filt_mode_vol), 64'(m_mv));
    endtask

    // One host write: we high for 'hi' cycles; commit expected 4 edges after rise.
    task automatic do_write(input int voice, input int addr, input logic [7:0] data,
                            input int rsv, input int hi, input bit scramble);
        int ncyc;
        ncyc = (hi > 4) ? hi : 4;
        @(negedge clk);
        ui_in  = {1'b0, 2'(rsv), 2'(voice), 3'(addr)};
        uio_in = data;
        @(negedge clk);
        ui_in[7] = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            if (c == hi) ui_in[7] = 1'b0;
            if (scramble && c >= 3 && ui_in[7]) begin
                ui_in[6:0] = 7'($urandom);
                uio_in     = 8'($urandom);
            end
            if (c == 3) begin
                check_eq("strobe_after_e2", 64'(wr_strobe), 64'd1);
                check_regs("pre_commit");
            end
            if (c == 4) begin
                model_write(voice, addr, data, rsv);
                check_eq("strobe_after_e3", 64'(wr_strobe), 64'd0);
                check_regs("post_commit");
                check_eq("wr_voice", 64'(wr_voice), 64'(m_voice));
                check_eq("wr_addr",  64'(wr_addr),  64'(m_addr));
            end
        end
        ui_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        exp_strobes++;
        check_eq("strobe_count", 64'(strobe_cnt), 64'(exp_strobes));
    endtask

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check_regs("reset");
        check_eq("reset.strobe", 64'(wr_strobe), 64'd0);
        check_eq("reset.wr_voice", 64'(wr_voice), 64'd0);
        rst_n = 1'b1;

        // Voice 0 programming sequence.
        do_write(0, 0, 8'h1D, 0, 2, 1'b0);
        do_write(0, 1, 8'h00, 0, 1, 1'b0);
        do_write(0, 2, 8'h00, 0, 3, 1'b0);
        do_write(0, 3, 8'h08, 0, 5, 1'b0);
        do_write(0, 4, 8'h99, 0, 2, 1'b0);
        do_write(0, 5, 8'hA9, 0, 4, 1'b0);
        do_write(0, 6, 8'h11, 0, 1, 1'b0);
        check_eq("v0_freq", 64'(voice_freq[15:0]), 64'h001D);
        check_eq("v0_pw",   64'(voice_pw[11:0]),   64'h800);
        check_eq("v0_ad",   64'(voice_ad[7:0]),    64'h99);
        check_eq("v0_sr",   64'(voice_sr[7:0]),    64'hA9);
        check_eq("v0_wav",  64'(voice_wav[7:0]),   64'h11);

        // Filter programming, including discarded fc_lo and pw_hi upper bits.
        do_write(3, 0, 8'h00, 0, 2, 1'b0);
        do_write(3, 1, 8'h04, 0, 2, 1'b0);
        do_write(3, 2, 8'h81, 0, 2, 1'b0);
        do_write(3, 3, 8'h1F, 0, 2, 1'b0);
        check_eq("mv_1f", 64'(filt_mode_vol), 64'h1F);
        do_write(3, 3, 8'h2F, 0, 2, 1'b0);
        check_eq("mv_2f", 64'(filt_mode_vol), 64'h2F);
        do_write(3, 3, 8'h4F, 0, 2, 1'b0);
        check_eq("fc_32", 64'(filt_fc), 64'd32);
        check_eq("res_81", 64'(filt_res_filt), 64'h81);
        check_eq("mv_4f", 64'(filt_mode_vol), 64'h4F);
        do_write(3, 0, 8'hFD, 0, 2, 1'b0);
        do_write(1, 3, 8'hF5, 0, 2, 1'b0);

        // Ignored addresses and reserved bits: pulse but no register change.
        do_write(2, 7, 8'hAA, 0, 2, 1'b0);
        do_write(3, 5, 8'hBB, 0, 2, 1'b0);
        do_write(0, 0, 8'hCC, 1, 2, 1'b0);

        // Long strobe with pins changing after E2: single write of latched data.
        do_write(1, 0, 8'h3C, 0, 100, 1'b1);

        // Random traffic.
        for (int i = 0; i < 40; i++) begin
            do_write(int'($urandom_range(0, 3)), int'($urandom_range(0, 7)), 8'($urandom),
                     ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 3)) : 0,
                     int'($urandom_range(1, 6)), 1'b0);
        end

        // Mid-cycle asynchronous reset.
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_regs("async_reset");
        check_eq("async_reset.strobe", 64'(wr_strobe), 64'd0);
        check_eq("async_reset.wr_addr", 64'(wr_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Reset between E2 and E3 aborts the commit.
        ui_in  = 8'h00;
        uio_in = 8'hFF;
        @(negedge clk);
        ui_in[7] = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("abort.strobe_e2", 64'(wr_strobe), 64'd1);
        exp_strobes++;
        #2;
        rst_n    = 1'b0;
        ui_in[7] = 1'b0;
        #1;
        check_eq("abort.strobe_cleared", 64'(wr_strobe), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check_regs("abort");
        check_eq("abort.strobe_count", 64'(strobe_cnt), 64'(exp_strobes));
        do_write(0, 0, 8'h5A, 0, 2, 1'b0);
        check_eq("after_abort.freq", 64'(voice_freq), 64'h5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
